// File: rtl/ov5640_seq_pkg.sv
// Shared types for the OV5640 power-up sequencer: fixed state encoding and
// the microsecond-to-cycle conversion used for all delays.
package ov5640_seq_pkg;

    typedef enum logic [2:0] {
        ST_PWDN  = 3'd0,
        ST_RST   = 3'd1,
        ST_INIT  = 3'd2,
        ST_CFG   = 3'd3,
        ST_READY = 3'd4
    } seq_state_e;

    function automatic int us_to_cycles(input int us, input int mhz);
        return us * mhz;
    endfunction

    function automatic int max2(input int a, input int b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/ov5640_power_seq_if.sv
// Sensor pin, SCCB-config handshake and status bundle of the power sequencer.
interface ov5640_power_seq_if;

    logic       reinit;
    logic       cfg_done;
    logic       cam_pwdn;
    logic       cam_rst_n;
    logic       cfg_start;
    logic       cam_ready;
    logic [2:0] seq_state;
    logic       cfg_err;

    modport master (
        input  reinit, cfg_done,
        output cam_pwdn, cam_rst_n, cfg_start, cam_ready, seq_state, cfg_err
    );

    modport slave (
        output reinit, cfg_done,
        input  cam_pwdn, cam_rst_n, cfg_start, cam_ready, seq_state, cfg_err
    );

endinterface

// File: rtl/seq_timer.sv
// Up-counter with synchronous clear that stops at a loadable terminal value
// and flags it; shared by the state delays and the config watchdog.
module seq_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [W-1:0] tc_val,
    output logic         tc
);

    logic [W-1:0] cnt_r;

    assign tc = (cnt_r == tc_val);

    // Cycle counter: cleared on reset or request, otherwise counts up to tc_val.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (!tc) begin
            cnt_r <= cnt_r + W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/ov5640_power_seq.sv
// OV5640 power-up sequencer: PWDN -> RESETB -> settle -> SCCB config -> ready.
// Optional config watchdog enabled by defining OV5640_CFG_TIMEOUT_EN.
module ov5640_power_seq
    import ov5640_seq_pkg::*;
#(
    parameter int CLK_FREQ_MHZ   = 24,
    parameter int T_PWDN_US      = 6000,
    parameter int T_RST_US       = 1000,
    parameter int T_INIT_US      = 20000,
    parameter int CFG_TIMEOUT_US = 500000
) (
    input  logic                       clk,
    input  logic                       rst,
    ov5640_power_seq_if.master         bus
);

    localparam int CYC_PWDN = us_to_cycles(T_PWDN_US, CLK_FREQ_MHZ);
    localparam int CYC_RST  = us_to_cycles(T_RST_US, CLK_FREQ_MHZ);
    localparam int CYC_INIT = us_to_cycles(T_INIT_US, CLK_FREQ_MHZ);
    localparam int CYC_TO   = us_to_cycles(CFG_TIMEOUT_US, CLK_FREQ_MHZ);

`ifdef OV5640_CFG_TIMEOUT_EN
    localparam int CYC_MAX = max2(max2(CYC_PWDN, CYC_RST), max2(CYC_INIT, CYC_TO));
`else
    localparam int CYC_MAX = max2(max2(CYC_PWDN, CYC_RST), CYC_INIT);
`endif
    localparam int CW = $clog2(CYC_MAX + 1);

    localparam logic [CW-1:0] TC_PWDN = CW'(CYC_PWDN - 1);
    localparam logic [CW-1:0] TC_RST  = CW'(CYC_RST - 1);
    localparam logic [CW-1:0] TC_INIT = CW'(CYC_INIT - 1);
`ifdef OV5640_CFG_TIMEOUT_EN
    localparam logic [CW-1:0] TC_TO   = CW'(CYC_TO - 1);
`endif

    if (CYC_PWDN <= 0 || CYC_RST <= 0 || CYC_INIT <= 0 || CYC_TO <= 0) begin : g_zero_delay
        $fatal(1, "ov5640_power_seq: every delay must be at least one cycle");
    end

    seq_state_e    state_r, state_s, seq_nxt_s;
    logic          clr_s;
    logic          tc_s;
    logic [CW-1:0] tc_val_s;
    logic          cam_pwdn_r, cam_rst_n_r, cfg_start_r, cam_ready_r;
`ifdef OV5640_CFG_TIMEOUT_EN
    logic          cfg_err_r, err_s, err_nxt_s;
`endif

    seq_timer #(.W(CW)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr_s),
        .tc_val (tc_val_s),
        .tc     (tc_s)
    );

    // Next-state selection; reinit overrides everything, including a timeout.
    always_comb begin
        seq_nxt_s = state_r;
        tc_val_s  = '1;
`ifdef OV5640_CFG_TIMEOUT_EN
        err_nxt_s = cfg_err_r;
`endif
        case (state_r)
            ST_PWDN: begin
                tc_val_s = TC_PWDN;
                if (tc_s) seq_nxt_s = ST_RST; else seq_nxt_s = ST_PWDN;
            end
            ST_RST: begin
                tc_val_s = TC_RST;
                if (tc_s) seq_nxt_s = ST_INIT; else seq_nxt_s = ST_RST;
            end
            ST_INIT: begin
                tc_val_s = TC_INIT;
                if (tc_s) seq_nxt_s = ST_CFG; else seq_nxt_s = ST_INIT;
            end
            ST_CFG: begin
`ifdef OV5640_CFG_TIMEOUT_EN
                tc_val_s = TC_TO;
                if (bus.cfg_done) begin
                    seq_nxt_s = ST_READY;
                end else if (tc_s) begin
                    seq_nxt_s = ST_PWDN;
                    err_nxt_s = 1'b1;
                end else begin
                    seq_nxt_s = ST_CFG;
                end
`else
                if (bus.cfg_done) seq_nxt_s = ST_READY; else seq_nxt_s = ST_CFG;
`endif
            end
            ST_READY: seq_nxt_s = ST_READY;
            default:  seq_nxt_s = ST_PWDN;
        endcase
        if (bus.reinit) state_s = ST_PWDN; else state_s = seq_nxt_s;
`ifdef OV5640_CFG_TIMEOUT_EN
        if (state_s == ST_READY) err_s = 1'b0; else err_s = err_nxt_s;
`endif
        clr_s = bus.reinit || (state_s != state_r);
    end

    // State and pin registers, all decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_PWDN;
            cam_pwdn_r  <= 1'b1;
            cam_rst_n_r <= 1'b0;
            cfg_start_r <= 1'b0;
            cam_ready_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            cam_pwdn_r  <= (state_s == ST_PWDN);
            cam_rst_n_r <= (state_s == ST_INIT) || (state_s == ST_CFG) || (state_s == ST_READY);
            cfg_start_r <= (state_s == ST_CFG) && (state_r != ST_CFG);
            cam_ready_r <= (state_s == ST_READY);
        end
    end

`ifdef OV5640_CFG_TIMEOUT_EN
    // Sticky watchdog flag, survives reinit, cleared by rst or reaching READY.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_err_r <= 1'b0;
        end else begin
            cfg_err_r <= err_s;
        end
    end
    assign bus.cfg_err = cfg_err_r;
`else
    assign bus.cfg_err = 1'b0;
`endif

    assign bus.cam_pwdn  = cam_pwdn_r;
    assign bus.cam_rst_n = cam_rst_n_r;
    assign bus.cfg_start = cfg_start_r;
    assign bus.cam_ready = cam_ready_r;
    assign bus.seq_state = state_r;

endmodule

// File: tb/tb_ov5640_power_seq.sv
// Self-checking bench for ov5640_power_seq: per-test stimulus plus a table of
// expected output checkpoints fed through a scoreboard queue.
module tb_ov5640_power_seq;

    logic clk = 1'b0;
    logic rst;

    ov5640_power_seq_if bus_if ();

    ov5640_power_seq #(
        .CLK_FREQ_MHZ   (1),
        .T_PWDN_US      (10),
        .T_RST_US       (5),
        .T_INIT_US      (20),
        .CFG_TIMEOUT_US (50)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         test;
        int         cyc;
        logic [2:0] st;
        logic       pwdn;
        logic       rst_n;
        logic       start;
        logic       ready;
        logic       err;
    } chk_t;

    chk_t table_q[$];
    chk_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic add(input int t, input int c, input logic [2:0] st, input logic pwdn,
                       input logic rst_n, input logic start, input logic ready, input logic err);
        chk_t e;
        e.test = t; e.cyc = c; e.st = st; e.pwdn = pwdn; e.rst_n = rst_n;
        e.start = start; e.ready = ready; e.err = err;
        table_q.push_back(e);
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_entry(input chk_t e);
        string tag;
        tag = $sformatf("t%0d_c%0d", e.test, e.cyc);
        cmp({tag, "_state"},     32'(bus_if.seq_state), 32'(e.st));
        cmp({tag, "_cam_pwdn"},  32'(bus_if.cam_pwdn),  32'(e.pwdn));
        cmp({tag, "_cam_rst_n"}, 32'(bus_if.cam_rst_n), 32'(e.rst_n));
        cmp({tag, "_cfg_start"}, 32'(bus_if.cfg_start), 32'(e.start));
        cmp({tag, "_cam_ready"}, 32'(bus_if.cam_ready), 32'(e.ready));
        cmp({tag, "_cfg_err"},   32'(bus_if.cfg_err),   32'(e.err));
    endtask

    // Returns {rst, reinit, cfg_done} to drive during cycle c of test t.
    function automatic logic [2:0] stim(input int t, input int c);
        case (t)
            1: begin
                if (c == 38 || c == 84) return 3'b001;
                if (c == 45) return 3'b110;
            end
            2: return 3'b001;
            3: begin
                if (c == 12) return 3'b010;
                if (c == 51) return 3'b001;
            end
            5: begin
                if (c == 36) return 3'b010;
                if (c == 40 || c == 75) return 3'b001;
            end
            6: begin
`ifdef OV5640_CFG_TIMEOUT_EN
                if (c == 122) return 3'b001;
`endif
            end
            default: ;
        endcase
        return 3'b000;
    endfunction

    task automatic run_test(input int t, input int ncyc);
        int   starts;
        chk_t e;
        starts = 0;
        rst = 1'b1; bus_if.reinit = 1'b0; bus_if.cfg_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int c = 0; c < ncyc; c++) begin
            {rst, bus_if.reinit, bus_if.cfg_done} = stim(t, c);
            foreach (table_q[i]) begin
                if (table_q[i].test == t && table_q[i].cyc == c + 1) sb_q.push_back(table_q[i]);
            end
            @(posedge clk);
            #1;
            if (t == 5 && c + 1 >= 37 && bus_if.cfg_start === 1'b1) starts++;
            while (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check_entry(e);
            end
        end
        if (t == 5) cmp("t5_single_cfg_start", 32'(starts), 32'd1);
    endtask

    initial begin
        // test 1 (+ rst with reinit in READY at cycle 45, restart at 46)
        add(1,  9, 3'd0, 1, 0, 0, 0, 0);
        add(1, 10, 3'd1, 0, 0, 0, 0, 0);
        add(1, 14, 3'd1, 0, 0, 0, 0, 0);
        add(1, 15, 3'd2, 0, 1, 0, 0, 0);
        add(1, 34, 3'd2, 0, 1, 0, 0, 0);
        add(1, 35, 3'd3, 0, 1, 1, 0, 0);
        add(1, 36, 3'd3, 0, 1, 0, 0, 0);
        add(1, 38, 3'd3, 0, 1, 0, 0, 0);
        add(1, 39, 3'd4, 0, 1, 0, 1, 0);
        add(1, 45, 3'd4, 0, 1, 0, 1, 0);
        add(1, 46, 3'd0, 1, 0, 0, 0, 0);
        add(1, 55, 3'd0, 1, 0, 0, 0, 0);
        add(1, 56, 3'd1, 0, 0, 0, 0, 0);
        add(1, 61, 3'd2, 0, 1, 0, 0, 0);
        add(1, 81, 3'd3, 0, 1, 1, 0, 0);
        add(1, 82, 3'd3, 0, 1, 0, 0, 0);
        add(1, 84, 3'd3, 0, 1, 0, 0, 0);
        add(1, 85, 3'd4, 0, 1, 0, 1, 0);
        // test 2: cfg_done held high throughout
        add(2, 10, 3'd1, 0, 0, 0, 0, 0);
        add(2, 15, 3'd2, 0, 1, 0, 0, 0);
        add(2, 35, 3'd3, 0, 1, 1, 0, 0);
        add(2, 36, 3'd4, 0, 1, 0, 1, 0);
        add(2, 40, 3'd4, 0, 1, 0, 1, 0);
        // test 3: reinit in RST at cycle 12
        add(3, 12, 3'd1, 0, 0, 0, 0, 0);
        add(3, 13, 3'd0, 1, 0, 0, 0, 0);
        add(3, 22, 3'd0, 1, 0, 0, 0, 0);
        add(3, 23, 3'd1, 0, 0, 0, 0, 0);
        add(3, 28, 3'd2, 0, 1, 0, 0, 0);
        add(3, 48, 3'd3, 0, 1, 1, 0, 0);
        add(3, 49, 3'd3, 0, 1, 0, 0, 0);
        add(3, 52, 3'd4, 0, 1, 0, 1, 0);
        // test 5: reinit in CFG, stray cfg_done in PWDN
        add(5, 36, 3'd3, 0, 1, 0, 0, 0);
        add(5, 37, 3'd0, 1, 0, 0, 0, 0);
        add(5, 41, 3'd0, 1, 0, 0, 0, 0);
        add(5, 47, 3'd1, 0, 0, 0, 0, 0);
        add(5, 52, 3'd2, 0, 1, 0, 0, 0);
        add(5, 71, 3'd2, 0, 1, 0, 0, 0);
        add(5, 72, 3'd3, 0, 1, 1, 0, 0);
        add(5, 73, 3'd3, 0, 1, 0, 0, 0);
        add(5, 76, 3'd4, 0, 1, 0, 1, 0);
        // test 6: no cfg_done at all
        add(6, 35, 3'd3, 0, 1, 1, 0, 0);
`ifdef OV5640_CFG_TIMEOUT_EN
        add(6, 84,  3'd3, 0, 1, 0, 0, 0);
        add(6, 85,  3'd0, 1, 0, 0, 0, 1);
        add(6, 95,  3'd1, 0, 0, 0, 0, 1);
        add(6, 120, 3'd3, 0, 1, 1, 0, 1);
        add(6, 121, 3'd3, 0, 1, 0, 0, 1);
        add(6, 123, 3'd4, 0, 1, 0, 1, 0);
`else
        add(6, 85,  3'd3, 0, 1, 0, 0, 0);
        add(6, 129, 3'd3, 0, 1, 0, 0, 0);
`endif

        // reset values while rst is held
        rst = 1'b1; bus_if.reinit = 1'b1; bus_if.cfg_done = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        cmp("reset_state",     32'(bus_if.seq_state), 32'd0);
        cmp("reset_cam_pwdn",  32'(bus_if.cam_pwdn),  32'd1);
        cmp("reset_cam_rst_n", 32'(bus_if.cam_rst_n), 32'd0);
        cmp("reset_cfg_start", 32'(bus_if.cfg_start), 32'd0);
        cmp("reset_cam_ready", 32'(bus_if.cam_ready), 32'd0);
        cmp("reset_cfg_err",   32'(bus_if.cfg_err),   32'd0);

        run_test(1, 90);
        run_test(2, 42);
        run_test(3, 56);
        run_test(5, 80);
        run_test(6, 130);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ov5640_power_seq.md
Name: ov5640_power_seq

Overview:
Camera power-up sequencer directly downstream of the clock/reset generator. It runs on the 24 MHz camera-clock domain and drives the OV5640 PWDN and RESETB pins with the datasheet timing. Once the sensor has settled, it hands off to the SCCB register-config block with a start/done handshake. It then asserts cam_ready so the capture path and SDRAM writer may begin.

Parameters:
CLK_FREQ_MHZ, 24, clock frequency in MHz (integer); all delays are converted to cycles as T_x_US*CLK_FREQ_MHZ
T_PWDN_US, 6000, time PWDN is held high after reset release
T_RST_US, 1000, time RESETB is held low after PWDN falls
T_INIT_US, 20000, settle time after RESETB rises, before SCCB access
CFG_TIMEOUT_US, 500000, cfg_done watchdog (used only with the optional feature)

Ports:
clk  in  1  camera-domain clock (24 MHz PLL output)
rst  in  1  synchronous active-high reset (inverse of the system reset-done)
reinit  in  1  single-cycle request to restart the full power sequence
cfg_done  in  1  SCCB config complete; sampled only in state CFG
cam_pwdn  out  1  to sensor PWDN pin, 1 = powered down
cam_rst_n  out  1  to sensor RESETB pin, 0 = in reset
cfg_start  out  1  single-cycle pulse to the SCCB config block
cam_ready  out  1  sensor configured; level signal
seq_state  out  3  current state encoding, for debug/LED
cfg_err  out  1  config timeout flag (tied 0 when the feature is off)

Behaviour:
- Single clock. rst is synchronous and active-high. All outputs are registered.
- Reset values: state=PWDN, cnt=0, cam_pwdn=1, cam_rst_n=0, cfg_start=0, cam_ready=0, cfg_err=0.
- The cycle counter cnt is $clog2(max cycles+1) bits wide. It clears on every state change.
- A timed state lasts exactly CYC cycles: it transitions on the edge where cnt==CYC-1.
- PWDN: cam_pwdn=1, cam_rst_n=0. After CYC_PWDN cycles -> RST.
- RST: cam_pwdn=0, cam_rst_n=0. After CYC_RST cycles -> INIT.
- INIT: cam_pwdn=0, cam_rst_n=1. After CYC_INIT cycles -> CFG.
- CFG: cfg_start=1 in the first cycle in CFG only. Waits for cfg_done=1 -> READY.
  - cfg_done asserted in the same cycle as cfg_start is accepted.
- READY: cam_ready=1. The state is held indefinitely.
- Output timing: cam_pwdn falls exactly CYC_PWDN cycles after the first cycle with rst=0. cam_rst_n rises exactly CYC_RST cycles after that.
- cfg_done outside CFG is ignored, with no effect on state.
- reinit=1 in any state -> next edge state=PWDN, cnt=0, with outputs taking PWDN values.
  - This restarts the count when already in PWDN.
  - It aborts CFG; no cfg_start is re-issued until CFG is re-entered.
- rst and reinit together: rst wins; the result is identical to rst alone.
- A zero-length delay parameter is illegal; elaboration fails via an assertion.
- seq_state encoding: PWDN=0, RST=1, INIT=2, CFG=3, READY=4.

Optional Feature:
Macro OV5640_CFG_TIMEOUT_EN.
- Defined: a watchdog counts cycles in CFG. If it reaches CFG_TIMEOUT_US*CLK_FREQ_MHZ without cfg_done:
  - cfg_err is set and the state returns to PWDN to retry the full sequence.
  - cfg_err is sticky; it clears on rst or on entry to READY.
  - reinit does not clear cfg_err.
- Undefined: no watchdog; CFG waits forever and cfg_err is constant 0.

Decomposition:
- Package ov5640_seq_pkg holds the state enum with its fixed encoding and a function us_to_cycles(us, mhz).
- Natural sub-module: seq_timer, a loadable cycle counter with clear and terminal-count outputs. It is shared by the state delays and the watchdog.

Test Plan:
(All tests use CLK_FREQ_MHZ=1, T_PWDN_US=10, T_RST_US=5, T_INIT_US=20, CFG_TIMEOUT_US=50.)
1. Release rst at cycle 0 and respond with cfg_done 3 cycles after cfg_start:
   - cam_pwdn falls at cycle 10 and cam_rst_n rises at 15.
   - cfg_start pulses for 1 cycle at 35.
   - cam_ready rises at 39.
2. Assert cfg_done permanently from cycle 0 -> it is ignored before CFG; READY is reached 1 cycle after cfg_start (cycle 36).
3. Pulse reinit at cycle 12 (in RST) -> cam_pwdn returns to 1 at 13 and falls at 23; the whole sequence is shifted by 13.
4. Assert rst and reinit together in READY -> all reset values appear and the sequence restarts as in test 1.
5. Pulse reinit during CFG, then give cfg_done while in PWDN -> no state change; a single new cfg_start appears at the re-entry to CFG.
6. With OV5640_CFG_TIMEOUT_EN defined and no cfg_done:
   - cfg_err rises at cycle 85 and the state returns to PWDN.
   - A second cfg_start appears at cycle 120.
   - Answering it clears cfg_err on entry to READY.
